// File: rtl/vx_task_dispatch.sv
// Task dispatcher: picks one producer per cycle (round-robin) and steers its task
// into the one-entry output register of a core port that still has credit.
// Core selection is round-robin (MODE 0) or least-loaded (MODE 1). Each core
// returns credit through a one-cycle done pulse per completed task.
module vx_task_dispatch #(
   parameter int NUM_INPUTS  = 1,
   parameter int NUM_OUTPUTS = 4,
   parameter int DATA_WIDTH  = 64,
   parameter int MAX_CREDITS = 4,
   parameter int MODE        = 0
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_INPUTS-1:0]                  in_valid,
   output logic [NUM_INPUTS-1:0]                  in_ready,
   input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  in_data,
   output logic [NUM_OUTPUTS-1:0]                 out_valid,
   input  logic [NUM_OUTPUTS-1:0]                 out_ready,
   output logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] out_data,
   input  logic [NUM_OUTPUTS-1:0]                 done,
   output logic                                   busy
);

   localparam int CW = $clog2(MAX_CREDITS + 1);
   localparam int IW = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
   localparam int OW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
   localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_CREDITS);
   // Larger than any rotation distance or credit count, used as "no candidate yet".
   localparam int NO_KEY = NUM_INPUTS + NUM_OUTPUTS + MAX_CREDITS + 1;

   // Architectural state
   logic [CW-1:0]                          r_count [NUM_OUTPUTS];
   logic [NUM_OUTPUTS-1:0]                 r_out_valid;
   logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] r_out_data;
   logic [IW-1:0]                          r_in_ptr;
   logic [OW-1:0]                          r_out_ptr;

   // Decision logic
   logic [NUM_OUTPUTS-1:0] w_eligible;
   logic [NUM_OUTPUTS-1:0] w_count_zero;
   logic [NUM_OUTPUTS-1:0] w_out_onehot;
   logic [NUM_INPUTS-1:0]  w_in_onehot;
   logic                   w_in_found;
   logic                   w_out_found;
   logic                   w_accept;
   logic [DATA_WIDTH-1:0]  w_in_data;
   int                     w_in_idx;
   int                     w_in_best;
   int                     w_out_idx;
   int                     w_out_best;

   // Per-core eligibility: credit left and the output register free or draining now.
   always_comb begin
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
         w_count_zero[j] = (r_count[j] == '0);
         w_eligible[j]   = (r_count[j] < CREDIT_MAX) && (!r_out_valid[j] || out_ready[j]);
      end
   end

   // Producer arbitration: nearest asserted in_valid at or after the input pointer.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves it
      // unassigned; otherwise synthesis would infer a latch to hold the old value.
      w_in_found  = 1'b0;
      w_in_idx    = 0;
      w_in_best   = NO_KEY;
      w_in_data   = '0;
      w_in_onehot = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (in_valid[i] &&
             ((i - int'(r_in_ptr) + NUM_INPUTS) % NUM_INPUTS) < w_in_best) begin
            w_in_found = 1'b1;
            w_in_idx   = i;
            w_in_best  = (i - int'(r_in_ptr) + NUM_INPUTS) % NUM_INPUTS;
            w_in_data  = in_data[i];
         end
      end
      for (int i = 0; i < NUM_INPUTS; i++) begin
         w_in_onehot[i] = w_in_found && (i == w_in_idx);
      end
   end

   // Core selection: rotation distance from the output pointer (MODE 0) or the
   // credit count (MODE 1); strict compare keeps the lowest index on ties.
   always_comb begin
      w_out_found = 1'b0;
      w_out_idx   = 0;
      w_out_best  = NO_KEY;
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
         if (w_eligible[j]) begin
            if (MODE == 1) begin
               if (int'(r_count[j]) < w_out_best) begin
                  w_out_found = 1'b1;
                  w_out_idx   = j;
                  w_out_best  = int'(r_count[j]);
               end
            end else begin
               if (((j - int'(r_out_ptr) + NUM_OUTPUTS) % NUM_OUTPUTS) < w_out_best) begin
                  w_out_found = 1'b1;
                  w_out_idx   = j;
                  w_out_best  = (j - int'(r_out_ptr) + NUM_OUTPUTS) % NUM_OUTPUTS;
               end
            end
         end
      end
   end

   // A task moves when both a producer and a core are available; nothing moves in reset.
   always_comb begin
      w_accept = !reset && w_in_found && w_out_found;
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
         w_out_onehot[j] = w_accept && (j == w_out_idx);
      end
      in_ready = (!reset && w_out_found) ? w_in_onehot : '0;
   end

   // Control state: output valids, credit counters and both round-robin pointers.
   always_ff @(posedge clk) begin
      // NOTE: state is written with non-blocking assignments so every register
      // samples pre-edge values; blocking here would create order-dependent races.
      if (reset) begin
         r_out_valid <= '0;
         r_in_ptr    <= '0;
         r_out_ptr   <= '0;
         for (int j = 0; j < NUM_OUTPUTS; j++) begin
            r_count[j] <= '0;
         end
      end else begin
         for (int j = 0; j < NUM_OUTPUTS; j++) begin
            if (w_out_onehot[j]) begin
               r_out_valid[j] <= 1'b1;
            end else if (out_ready[j]) begin
               r_out_valid[j] <= 1'b0;
            end
            // A done with no credit outstanding is dropped so the counter never wraps.
            r_count[j] <= r_count[j] + CW'(w_out_onehot[j])
                                     - CW'(done[j] && !w_count_zero[j]);
         end
         if (w_accept) begin
            r_in_ptr <= IW'((w_in_idx + 1) % NUM_INPUTS);
            if (MODE == 0) begin
               r_out_ptr <= OW'((w_out_idx + 1) % NUM_OUTPUTS);
            end
         end
      end
   end

   // Payload registers: loaded on accept, qualified by r_out_valid.
   always_ff @(posedge clk) begin
      // NOTE: the data array has no reset; its content is meaningless while the
      // matching valid bit is low, and leaving it unreset keeps it plain flops.
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
         if (w_out_onehot[j]) begin
            r_out_data[j] <= w_in_data;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = (|r_out_valid) || !(&w_count_zero);

   // A core must never return more completions than tasks it was given.
   a_done_without_credit: assert property (@(posedge clk) disable iff (reset)
      (done & w_count_zero) == '0);

endmodule

// File: doc/vx_task_dispatch.md
VX_TASK_DISPATCH -- requirements
Module: VX_task_dispatch

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 1: number of task producers (>=1).
REQ-002 SHALL have parameter NUM_OUTPUTS, default 4: number of core task ports (>=1).
REQ-003 SHALL have parameter DATA_WIDTH, default 64: task payload bits.
REQ-004 SHALL have parameter MAX_CREDITS, default 4: maximum outstanding tasks per output (>=1).
REQ-005 SHALL have parameter MODE, default 0: output selection policy, 0 = round-robin, 1 = least-loaded.
REQ-006 SHALL have port clk  input  1  clock; one clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous active-high reset.
REQ-008 SHALL have ports in_valid / in_ready  input / output  NUM_INPUTS each  per-producer handshake.
REQ-009 SHALL have port in_data  input  NUM_INPUTS x DATA_WIDTH  producer payloads.
REQ-010 SHALL have ports out_valid / out_ready  output / input  NUM_OUTPUTS each  per-core handshake.
REQ-011 SHALL have port out_data  output  NUM_OUTPUTS x DATA_WIDTH  core payloads.
REQ-012 SHALL have port done  input  NUM_OUTPUTS  one-cycle pulse per completed task, returns one credit.
REQ-013 SHALL have port busy  output  1  tasks in flight or buffered.

Function
REQ-014 SHALL keep per output a credit count, width clog2(MAX_CREDITS+1), and a one-entry output register (valid + data).
REQ-015 SHALL deem output j eligible when count[j] < MAX_CREDITS and (register j empty or out_valid[j]&&out_ready[j] this cycle).
REQ-016 SHALL accept at most one task per cycle; input chosen round-robin among asserted in_valid, starting one past the last accepted input.
REQ-017 SHALL assert in_ready[i] only for the chosen input and only when at least one output is eligible; all other in_ready low.
REQ-018 SHALL, in MODE 0, pick the first eligible output at or after the round-robin pointer; the pointer moves to chosen+1 (mod NUM_OUTPUTS) on accept only.
REQ-019 SHALL, in MODE 1, pick the eligible output with minimum count; ties go to the lowest index.
REQ-020 SHALL present an accepted task on out_valid/out_data of the chosen output on the next cycle (latency 1).
REQ-021 SHALL hold out_valid and out_data stable until out_ready; out_valid deasserts the cycle after the handshake unless refilled in that same cycle.
REQ-022 SHALL increment count[j] on accept to j, decrement on done[j]; both in one cycle leaves count unchanged.
REQ-023 SHALL ignore done[j] when count[j]==0 and fire a simulation assertion; count never wraps.
REQ-024 SHALL drive busy = (any count nonzero) or (any out_valid), registered-state only, no combinational path from inputs.
REQ-025 SHALL make in_ready independent of in_valid of the same input except through arbitration; out_valid independent of out_ready.
REQ-026 SHALL pass out_data unmodified from the accepted in_data.

Reset
REQ-027 SHALL on reset clear all out_valid, counts, in_ready, busy to 0 and both round-robin pointers to 0.
REQ-028 SHALL on reset mid-operation discard buffered tasks and outstanding credits; done pulses during reset are ignored.
REQ-029 SHALL accept a task on the first cycle after reset deasserts.

Verification
REQ-030 SHALL cover: MODE 0, 1 input, 4 outputs, out_ready=1, 6 tasks, no done -> outputs 0,1,2,3,0,1; counts 2,2,1,1.
REQ-031 SHALL cover: MAX_CREDITS=2, 2 outputs, 5 back-to-back tasks, no done -> 4 accepted, in_ready low thereafter, busy=1; done[1] pulse -> 5th task to output 1 next cycle.
REQ-032 SHALL cover: MODE 1, counts {3,1,1,2}, new task -> output 1; simultaneous accept to j and done[j] -> count[j] unchanged.
REQ-033 SHALL cover: 3 inputs all valid continuously -> accepts in order 0,1,2,0; payloads 0xA,0xB,0xC arrive unmodified.
REQ-034 SHALL cover: out_ready[0]=0 with task held on output 0 -> out_data[0] stable, MODE 0 skips output 0 for new tasks; out_ready and refill same cycle -> out_valid stays 1 with new data.
REQ-035 SHALL cover: reset with 3 tasks in flight -> next cycle all out_valid=0, busy=0, first post-reset task to output 0.
